down_counter_32: RTL

- Loadable 32-bit down-counter with terminal-count pulse and optional auto-reload.
- Counterpart to the team's up-counting path: it counts toward zero instead of away from it.
- Used as a programmable interval timer or event countdown beside the 32-bit adder and counter blocks.
- Decrement is performed by the team's ripple adder (adder_32) adding all-ones; count state and control are registered here.

---
 rtl/down_counter_32_pkg.sv | 16 +
 rtl/down_counter_32_adder.sv | 28 ++
 rtl/down_counter_32.sv | 109 ++++++++++
 3 files changed

// File: rtl/down_counter_32_pkg.sv
// Shared definitions for the 32-bit down-counter slice.
//   state_t      : FSM encoding (IDLE=0, RUN=1)
//   WIDTH        : counter / load-value width
//   DEC_OPERAND  : all-ones addend; adding it with Cin=0 subtracts one
package down_counter_32_pkg;

    localparam int WIDTH = 32;

    localparam logic [WIDTH-1:0] DEC_OPERAND = {WIDTH{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/down_counter_32_adder.sv
// adder_32: 32-bit ripple-carry adder built from a chain of full adders.
// Ports:
//   a, b  : addends
//   cin   : carry in
//   sum   : a + b + cin (low 32 bits)
//   cout  : carry out of bit 31
module adder_32
    import down_counter_32_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/down_counter_32.sv
// down_counter_32: loadable down-counter with terminal-count pulse,
// sticky done flag and optional auto-reload.
// Ports:
//   clk         : rising-edge clock
//   rst         : asynchronous active-high reset
//   load        : load strobe (highest priority)
//   load_val    : start / reload value, sampled on load
//   en          : count enable
//   auto_reload : on expiry, 1 = restart from reload value, 0 = stop at zero
//   count       : current count (registered)
//   running     : state == RUN
//   tc          : one-cycle terminal-count pulse per expiry
//   done        : sticky expiry flag, cleared by load
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | stopped; count holds, en ignored
// RUN   | counting down one step per enabled cycle
module down_counter_32
    import down_counter_32_pkg::*;
#(
    parameter int WIDTH = down_counter_32_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             tc,
    output logic             done
);

    state_t           state, state_next;
    logic [WIDTH-1:0] reload_reg, reload_next;
    logic [WIDTH-1:0] count_next;
    logic             tc_next, done_next;

    logic [WIDTH-1:0] dec_sum;
    logic             dec_cout_unused;

    // Decrement = count + all-ones with no carry in; the carry out is meaningless here.
    adder_32 u_dec (
        .a    (count),
        .b    (DEC_OPERAND),
        .cin  (1'b0),
        .sum  (dec_sum),
        .cout (dec_cout_unused)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            reload_reg <= '0;
            tc         <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            reload_reg <= reload_next;
            tc         <= tc_next;
            done       <= done_next;
        end
    end

    always_comb begin
        state_next  = state;
        count_next  = count;
        reload_next = reload_reg;
        tc_next     = 1'b0;
        done_next   = done;

        if (load) begin
            reload_next = load_val;
            count_next  = load_val;
            done_next   = 1'b0;
            state_next  = (load_val != '0) ? RUN : IDLE;
        end else begin
            case (state)
                RUN: begin
                    if (en) begin
                        if (count == WIDTH'(1)) begin
                            tc_next   = 1'b1;
                            done_next = 1'b1;
                            if (auto_reload) begin
                                count_next = reload_reg;
                            end else begin
                                count_next = '0;
                                state_next = IDLE;
                            end
                        end else if (count != '0) begin
                            count_next = dec_sum;
                        end else begin
                            // Zero in RUN is unreachable; never decrement through it.
                            state_next = IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign running = (state == RUN);

endmodule
